// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external RV32I ALU between two requesters (port 0: execute stage,
// port 1: branch/address-generation unit). A round-robin arbiter loads a
// two-stage pipeline:
//   issue register    -> drives the ALU operands and op bundle
//   response register -> captures the ALU result and the requester id
// Both sides use valid/ready handshakes with full backpressure. The block
// holds at most two operations (one per stage).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous discard of all in-flight operations
//   req_valid/req_ready per-requester handshake (req_ready is combinational)
//   req{0,1}_a/_b/_op   per-requester operands and op bundle
//   alu_a/alu_b/alu_op  registered ALU inputs
//   alu_y               combinational ALU result
//   rsp_valid/rsp_ready result handshake
//   rsp_data/rsp_id     registered result and issuing requester
//   busy                any operation in flight
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [OPW-1:0]  req0_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [OPW-1:0]  req1_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] alu_y,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_id,
    output logic            busy
);

    // Pipeline state
    logic            iss_valid_q, iss_valid_d;
    logic            iss_id_q, iss_id_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_id_q, rsp_id_d;
    logic            last_grant_q, last_grant_d;

    // Requester payloads gathered into arrays so the grant index selects them
    logic [XLEN-1:0] req_a  [2];
    logic [XLEN-1:0] req_b  [2];
    logic [OPW-1:0]  req_op [2];

    assign req_a[0]  = req0_a;
    assign req_b[0]  = req0_b;
    assign req_op[0] = req0_op;
    assign req_a[1]  = req1_a;
    assign req_b[1]  = req1_b;
    assign req_op[1] = req1_op;

    logic       rsp_free;
    logic       iss_adv;
    logic       iss_free;
    logic [1:0] grant;
    logic       grant_id;
    logic       accept;

    // The response slot can take new data if empty or draining this cycle;
    // the issue slot can take new data if empty or moving forward this cycle.
    assign rsp_free = ~rsp_valid_q | rsp_ready;
    assign iss_adv  = iss_valid_q & rsp_free;
    assign iss_free = ~iss_valid_q | iss_adv;

    // Round-robin: on contention the requester that did not win last time goes.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign grant_id = grant[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant[gi] & iss_free & ~flush;
        end
    endgenerate

    assign accept = |(req_valid & req_ready);

    always_comb begin
        iss_valid_d  = iss_valid_q;
        iss_id_d     = iss_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;

        if (flush) begin
            // Datapath and arbitration history are left untouched.
            iss_valid_d = 1'b0;
            rsp_valid_d = 1'b0;
        end else begin
            // Response stage: refill wins over drain so a simultaneous
            // consume-and-refill keeps rsp_valid high with fresh data.
            if (iss_adv) begin
                rsp_data_d  = alu_y;
                rsp_id_d    = iss_id_q;
                rsp_valid_d = 1'b1;
            end else if (rsp_valid_q & rsp_ready) begin
                rsp_valid_d = 1'b0;
            end

            // Issue stage
            if (accept) begin
                alu_a_d      = req_a[grant_id];
                alu_b_d      = req_b[grant_id];
                alu_op_d     = req_op[grant_id];
                iss_id_d     = grant_id;
                iss_valid_d  = 1'b1;
                last_grant_d = grant_id;
            end else if (iss_adv) begin
                iss_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q  <= 1'b0;
            iss_id_q     <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first contention
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_id_q     <= iss_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = iss_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter with directed scenarios followed by random traffic, and
// provides a behavioural RV32I ALU on alu_a/alu_b/alu_op -> alu_y. A reference
// model keeps the in-flight operations as an ordered queue of
// {requester id, expected result}; the head is the oldest op and sits in the
// response slot once it has had one cycle to move there.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    localparam int XLEN = 32;
    localparam int OPW  = 17;

    logic            clk;
    logic            rst;
    logic            flush;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]  req0_op, req1_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic [OPW-1:0]  alu_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_id;
    logic            busy;

    alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RV32I ALU: funct3 selects the operation, funct7[5] selects
    // SUB (register form only) and SRA.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [16:0] op);
        logic alt;
        alt = op[15];
        case (op[9:7])
            3'd0:    return (alt && op[6:0] == 7'b0110011) ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_y = alu_fn(alu_a, alu_b, alu_op);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        id;
        logic [31:0] y;
    } item_t;

    item_t q[$];
    bit    rsp_has;
    bit    m_last;

    // Pending requests (held until accepted)
    logic [1:0]  pv;
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [16:0] pop [2];

    int n_cmp;
    int n_bad;

    localparam logic [16:0] OP_ADDI = {7'b0, 3'b000, 7'b0010011};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = pv;
        req0_a    = pa[0];
        req0_b    = pb[0];
        req0_op   = pop[0];
        req1_a    = pa[1];
        req1_b    = pb[1];
        req1_op   = pop[1];
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [16:0] op);
        pv[i]  = 1'b1;
        pa[i]  = a;
        pb[i]  = b;
        pop[i] = op;
    endtask

    task automatic rand_req(input int i);
        logic [31:0] r;
        logic [31:0] b;
        r = $urandom;
        b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        case ($urandom_range(0, 3))
            0:       r[16:0] = {r[16:10], r[9:7], 7'b0010011};
            1:       r[16:0] = {1'b0, r[15], 5'b0, r[9:7], 7'b0110011};
            default: ;
        endcase
        set_req(i, $urandom, b, r[16:0]);
    endtask

    // One clock cycle: called just after a falling edge with stimulus chosen.
    // Checks outputs against the model, crosses the rising edge, advances the
    // model and returns at the next falling edge.
    task automatic step();
        logic [1:0] g;
        logic [1:0] exp_rdy;
        bit         iss_has, rsp_free, iss_free;
        int         k;
        drive();
        #1;
        iss_has  = q.size() > (rsp_has ? 1 : 0);
        rsp_free = !rsp_has || rsp_ready;
        iss_free = !iss_has || rsp_free;
        case (req_valid)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = m_last ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        exp_rdy = (iss_free && !flush) ? g : 2'b00;
        if (!rst) check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(rsp_has));
        check("busy", 32'(busy), 32'(q.size() != 0));
        if (rsp_has) begin
            check("rsp_data", rsp_data, q[0].y);
            check("rsp_id", 32'(rsp_id), 32'(q[0].id));
        end
        @(posedge clk);
        k = -1;
        if (rst) begin
            q.delete();
            rsp_has = 0;
            m_last  = 1;
        end else if (flush) begin
            q.delete();
            rsp_has = 0;
        end else begin
            if (rsp_has && rsp_ready) begin
                q.delete(0);
                rsp_has = 0;
            end
            if (iss_has && rsp_free) rsp_has = 1;
            if ((exp_rdy & req_valid) != 2'b00) begin
                k = exp_rdy[1] ? 1 : 0;
                q.push_back('{id: exp_rdy[1], y: alu_fn(pa[k], pb[k], pop[k])});
                m_last = exp_rdy[1];
            end
        end
        @(negedge clk);
        if (k >= 0) pv[k] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        pv        = 2'b00;
        for (int i = 0; i < 2; i++) begin
            pa[i]  = '0;
            pb[i]  = '0;
            pop[i] = '0;
        end
        drive();
        q.delete();
        rsp_has = 0;
        m_last  = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single op: 5 + 7 on requester 0
        rsp_ready = 1'b1;
        set_req(0, 32'd5, 32'd7, OP_ADDI);
        drive();
        #1;
        check("single_ready", 32'(req_ready), 32'd1);
        step();
        check("single_lat0", 32'(rsp_valid), 32'd0);
        step();
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_sum", rsp_data, 32'd12);
        check("single_id", 32'(rsp_id), 32'd0);
        step();

        // Contention after reset: grants alternate 0,1,0,1 without gaps
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i]) set_req(i, 32'(100 * i + k), 32'(k), OP_ADDI);
            if (k >= 2) begin
                check("cont_valid", 32'(rsp_valid), 32'd1);
                check("cont_id", 32'(rsp_id), 32'((k - 2) % 2));
            end
            step();
        end
        pv = 2'b00;
        for (int k = 0; k < 3; k++) step();

        // Backpressure: 1+1, 2+2, 3+3 with the consumer stalled
        rsp_ready = 1'b0;
        set_req(0, 32'd1, 32'd1, OP_ADDI);
        step();
        set_req(0, 32'd2, 32'd2, OP_ADDI);
        step();
        set_req(0, 32'd3, 32'd3, OP_ADDI);
        drive();
        #1;
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_hold", rsp_data, 32'd2);
        step();
        step();
        check("bp_hold2", rsp_data, 32'd2);
        check("bp_pend", 32'(pv[0]), 32'd1);
        rsp_ready = 1'b1;
        step();
        // consume 2 and refill with 4 at the same edge
        check("refill_valid", 32'(rsp_valid), 32'd1);
        check("refill_data", rsp_data, 32'd4);
        step();
        check("bp_last", rsp_data, 32'd6);
        step();
        check("bp_drained", 32'(busy), 32'd0);

        // Flush with two ops in flight
        rsp_ready = 1'b0;
        set_req(0, 32'd10, 32'd1, OP_ADDI);
        set_req(1, 32'd20, 32'd2, OP_ADDI);
        step();
        step();
        check("fl_full", 32'(busy), 32'd1);
        flush = 1'b1;
        drive();
        #1;
        check("fl_ready", 32'(req_ready), 32'd0);
        step();
        flush = 1'b0;
        check("fl_valid", 32'(rsp_valid), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        pv = 2'b00;
        set_req(1, 32'd40, 32'd2, OP_ADDI);
        step();
        step();
        check("fl_after", rsp_data, 32'd42);
        step();

        // Reset with both stages full, then contention restarts at requester 0
        rsp_ready = 1'b0;
        set_req(0, 32'd7, 32'd7, OP_ADDI);
        set_req(1, 32'd8, 32'd8, OP_ADDI);
        step();
        step();
        do_reset();
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_data", rsp_data, 32'd0);
        pv = 2'b00;
        set_req(0, 32'd1, 32'd2, OP_ADDI);
        set_req(1, 32'd3, 32'd4, OP_ADDI);
        drive();
        #1;
        check("mid_rst_grant", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i] && $urandom_range(0, 2) != 0) rand_req(i);
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
